// File: rtl/munoc_ahb2axi_bridge_pkg.sv
// Shared encodings, packed AXI channel layout and FSM states for the AHB-lite to AXI4 bridge.
package munoc_ahb2axi_bridge_pkg;

  localparam logic [1:0] AHB_TRANS_IDLE   = 2'b00;
  localparam logic [1:0] AHB_TRANS_BUSY   = 2'b01;
  localparam logic [1:0] AHB_TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] AHB_TRANS_SEQ    = 2'b11;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // AR/AW packing, LSB first: prot, cache, lock, burst, size, len, addr, id
  localparam int AX_PROT_LSB  = 0;
  localparam int AX_CACHE_LSB = 3;
  localparam int AX_LOCK_LSB  = 7;
  localparam int AX_BURST_LSB = 8;
  localparam int AX_SIZE_LSB  = 10;
  localparam int AX_LEN_LSB   = 13;
  localparam int AX_ADDR_LSB  = 21;

  // W packing, LSB first: last, strb, data, id
  localparam int W_LAST_LSB = 0;
  localparam int W_STRB_LSB = 1;

  function automatic int bw_archannel(int bw_id, int bw_addr);
    return bw_id + bw_addr + AX_ADDR_LSB;
  endfunction

  function automatic int bw_awchannel(int bw_id, int bw_addr);
    return bw_id + bw_addr + AX_ADDR_LSB;
  endfunction

  function automatic int bw_wchannel(int bw_id, int bw_data);
    return bw_id + bw_data + bw_data / 8 + 1;
  endfunction

  function automatic logic resp_is_err(logic [1:0] resp);
    return resp[1];
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_ERR1    = 3'd5,
    ST_ERR2    = 3'd6
  } state_e;

endpackage

// File: rtl/munoc_ahb2axi_bridge_if.sv
// AHB-lite request side plus packed AXI channels. master = the bridge, slave = AHB master and AXI fabric.
interface munoc_ahb2axi_bridge_if
  import munoc_ahb2axi_bridge_pkg::*;
#(
  parameter int BW_ADDR = 32,
  parameter int BW_DATA = 32,
  parameter int BW_ID   = 1
);
  localparam int BW_AR = bw_archannel(BW_ID, BW_ADDR);
  localparam int BW_AW = bw_awchannel(BW_ID, BW_ADDR);
  localparam int BW_W  = bw_wchannel(0, BW_DATA);

  logic [BW_ADDR-1:0] rhaddr;
  logic [2:0]         rhburst;
  logic               rhmasterlock;
  logic [3:0]         rhprot;
  logic [2:0]         rhsize;
  logic [1:0]         rhtrans;
  logic               rhwrite;
  logic [BW_DATA-1:0] rhwdata;
  logic [BW_DATA-1:0] rhrdata;
  logic               rhready;
  logic               rhresp;

  logic               sxarvalid;
  logic               sxarready;
  logic [BW_AR-1:0]   sxarchannel;
  logic               sxawvalid;
  logic               sxawready;
  logic [BW_AW-1:0]   sxawchannel;
  logic               sxwvalid;
  logic               sxwready;
  logic [BW_W-1:0]    sxwchannel;
  logic               sxbvalid;
  logic               sxbready;
  logic [1:0]         sxbresp;
  logic               sxrvalid;
  logic               sxrready;
  logic [BW_DATA-1:0] sxrdata;
  logic [1:0]         sxrresp;
  logic               sxrlast;

  modport master (
    input  rhaddr, rhburst, rhmasterlock, rhprot, rhsize, rhtrans, rhwrite, rhwdata,
    output rhrdata, rhready, rhresp,
    output sxarvalid, sxarchannel, sxawvalid, sxawchannel, sxwvalid, sxwchannel,
    input  sxarready, sxawready, sxwready,
    input  sxbvalid, sxbresp, sxrvalid, sxrdata, sxrresp, sxrlast,
    output sxbready, sxrready
  );

  modport slave (
    output rhaddr, rhburst, rhmasterlock, rhprot, rhsize, rhtrans, rhwrite, rhwdata,
    input  rhrdata, rhready, rhresp,
    input  sxarvalid, sxarchannel, sxawvalid, sxawchannel, sxwvalid, sxwchannel,
    output sxarready, sxawready, sxwready,
    output sxbvalid, sxbresp, sxrvalid, sxrdata, sxrresp, sxrlast,
    input  sxbready, sxrready
  );

endinterface

// File: rtl/munoc_ahb2axi_bridge_strobe_gen.sv
// Byte-lane write strobe from transfer size and the address offset inside the data word.
module munoc_ahb2axi_bridge_strobe_gen #(
  parameter int BW_DATA = 32
) (
  input  logic [2:0]                     size,
  input  logic [$clog2(BW_DATA/8)-1:0]   addr_lsb,
  output logic [BW_DATA/8-1:0]           strb
);
  localparam int NB = BW_DATA / 8;

  logic [NB-1:0] mask;

  always_comb begin
    mask = '0;
    for (int i = 0; i < NB; i++) mask[i] = (i < (1 << size));
  end

  assign strb = mask << addr_lsb;

endmodule

// File: rtl/munoc_ahb2axi_bridge.sv
// AHB-lite to single-beat AXI4 bridge with posted or blocking writes.
// Optional MUNOC_AHB2AXI_POSTED_ERROR_FLAG_EN adds a sticky posted-write error flag.
//
// state      | meaning
// IDLE       | rhready=1, waiting for an address phase
// RD_ADDR    | AR pending (held off while posted writes are outstanding)
// RD_DATA    | waiting for R
// WR_REQ     | AW and W pending (held off while posted limit is reached)
// WR_RESP    | blocking write, waiting for B
// ERR1       | first ERROR cycle, rhready=0
// ERR2       | second ERROR cycle, rhready=1, may accept a new transfer
module munoc_ahb2axi_bridge
  import munoc_ahb2axi_bridge_pkg::*;
#(
  parameter int BW_ADDR             = 32,
  parameter int BW_DATA             = 32,
  parameter int BW_ID               = 1,
  parameter int WAIT_WRITE_RESPONSE = 0,
  parameter int MAX_POSTED          = 4
) (
  input  logic clk,
  input  logic rstnn,
  input  logic comm_disable,
`ifdef MUNOC_AHB2AXI_POSTED_ERROR_FLAG_EN
  output logic posted_err,
  input  logic posted_err_clear,
`endif
  munoc_ahb2axi_bridge_if.master bus
);
  localparam int   NB   = BW_DATA / 8;
  localparam int   LSBW = $clog2(NB);
  localparam logic WWR  = (WAIT_WRITE_RESPONSE != 0);

  state_e             state, state_d;
  logic [BW_ADDR-1:0] addr_q;
  logic [2:0]         size_q;
  logic [2:0]         prot_q;
  logic               lock_q;
  logic [BW_DATA-1:0] rdata_q;
  logic               aw_done, w_done;
  logic [3:0]         posted_cnt;
  logic [NB-1:0]      wstrb;

  logic rhready, capture, can_post, ar_free;
  logic arvalid, awvalid, wvalid, aw_hs, w_hs, wr_done, post_inc, post_dec;
  logic unused_ok;

  assign rhready  = (state == ST_IDLE) || (state == ST_ERR2);
  assign capture  = rhready && (bus.rhtrans == AHB_TRANS_NONSEQ || bus.rhtrans == AHB_TRANS_SEQ);
  assign can_post = WWR || (posted_cnt < 4'(MAX_POSTED));
  // reads wait for all posted writes so they cannot overtake them
  assign ar_free  = (posted_cnt == 4'd0);

  assign arvalid  = (state == ST_RD_ADDR) && ar_free;
  assign awvalid  = (state == ST_WR_REQ) && can_post && !aw_done;
  assign wvalid   = (state == ST_WR_REQ) && can_post && !w_done;
  assign aw_hs    = awvalid && bus.sxawready;
  assign w_hs     = wvalid && bus.sxwready;
  assign wr_done  = (aw_done || aw_hs) && (w_done || w_hs);
  assign post_inc = !WWR && (state == ST_WR_REQ) && wr_done;
  assign post_dec = !WWR && bus.sxbvalid;

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE, ST_ERR2: begin
        state_d = ST_IDLE;
        if (capture) begin
          if (comm_disable)     state_d = ST_ERR1;
          else if (bus.rhwrite) state_d = ST_WR_REQ;
          else                  state_d = ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: if (arvalid && bus.sxarready) state_d = ST_RD_DATA;
      ST_RD_DATA: if (bus.sxrvalid) state_d = resp_is_err(bus.sxrresp) ? ST_ERR1 : ST_IDLE;
      ST_WR_REQ:  if (wr_done) state_d = WWR ? ST_WR_RESP : ST_IDLE;
      ST_WR_RESP: if (bus.sxbvalid) state_d = resp_is_err(bus.sxbresp) ? ST_ERR1 : ST_IDLE;
      ST_ERR1:    state_d = ST_ERR2;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      addr_q     <= '0;
      size_q     <= '0;
      prot_q     <= '0;
      lock_q     <= 1'b0;
      rdata_q    <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      posted_cnt <= '0;
    end else begin
      if (capture) begin
        addr_q <= bus.rhaddr;
        size_q <= bus.rhsize;
        lock_q <= bus.rhmasterlock;
        prot_q <= {~bus.rhprot[0], 1'b0, bus.rhprot[1]};
      end
      if (state == ST_RD_DATA && bus.sxrvalid) rdata_q <= bus.sxrdata;
      aw_done <= (state == ST_WR_REQ) && !wr_done && (aw_done || aw_hs);
      w_done  <= (state == ST_WR_REQ) && !wr_done && (w_done || w_hs);
      if (post_inc && !post_dec)
        posted_cnt <= posted_cnt + 4'd1;
      else if (post_dec && !post_inc && posted_cnt != 4'd0)
        posted_cnt <= posted_cnt - 4'd1;
    end
  end

`ifdef MUNOC_AHB2AXI_POSTED_ERROR_FLAG_EN
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn)                                        posted_err <= 1'b0;
    else if (post_dec && bus.sxbresp != AXI_RESP_OKAY) posted_err <= 1'b1;
    else if (posted_err_clear)                         posted_err <= 1'b0;
  end
`endif

  munoc_ahb2axi_bridge_strobe_gen #(.BW_DATA(BW_DATA)) u_strobe_gen (
    .size     (size_q),
    .addr_lsb (addr_q[LSBW-1:0]),
    .strb     (wstrb)
  );

  assign bus.rhready     = rhready;
  assign bus.rhresp      = (state == ST_ERR1) || (state == ST_ERR2);
  assign bus.rhrdata     = rdata_q;
  assign bus.sxarvalid   = arvalid;
  assign bus.sxawvalid   = awvalid;
  assign bus.sxwvalid    = wvalid;
  assign bus.sxrready    = (state == ST_RD_DATA);
  assign bus.sxbready    = 1'b1;
  assign bus.sxarchannel = {{BW_ID{1'b0}}, addr_q, 8'd0, size_q, AXI_BURST_INCR, lock_q, 4'd0, prot_q};
  assign bus.sxawchannel = {{BW_ID{1'b0}}, addr_q, 8'd0, size_q, AXI_BURST_INCR, lock_q, 4'd0, prot_q};
  assign bus.sxwchannel  = {bus.rhwdata, wstrb, 1'b1};

  assign unused_ok = ^{bus.rhburst, bus.rhprot[3:2], bus.sxrlast};

endmodule

// File: doc/munoc_ahb2axi_bridge.md
Name:
munoc_ahb2axi_bridge

Overview:
- Converts AHB-lite master transfers into single-beat AXI4 transactions on one ID.
- Sits directly upstream of the MUNOC master packetizer, which consumes packed AR/AW/W channels and returns B/R.
- One AHB beat becomes one AXI transaction (len=0); bursts are issued beat by beat.
- Supports posted writes with bounded outstanding count, or fully blocking writes.

Parameters:
- BW_ADDR, 32, platform address width.
- BW_DATA, 32, data width (32 or 64).
- BW_ID, 1, AXI ID width; ID is driven constant 0.
- WAIT_WRITE_RESPONSE, 0: 1 holds rhready until B is received; 0 posts writes.
- MAX_POSTED, 4, maximum outstanding posted writes (1..15); ignored when WAIT_WRITE_RESPONSE=1.

Ports:
- clk  in  1  clock
- rstnn  in  1  asynchronous active-low reset
- comm_disable  in  1  reject new transfers with AHB ERROR
- rhaddr/rhburst/rhmasterlock/rhprot/rhsize/rhtrans/rhwrite/rhwdata  in  AHB widths  AHB-lite master request
- rhrdata  out  BW_DATA  read data
- rhready  out  1  transfer done
- rhresp  out  1  1 = ERROR
- sxarvalid/sxarready  out/in  1  AR handshake
- sxarchannel  out  BW_ARCHANNEL(BW_ID,BW_ADDR)  packed AR fields
- sxawvalid/sxawready  out/in  1  AW handshake
- sxawchannel  out  BW_AWCHANNEL(BW_ID,BW_ADDR)  packed AW fields
- sxwvalid/sxwready  out/in  1  W handshake
- sxwchannel  out  BW_WCHANNEL(0,BW_DATA)  data, strobe, last=1
- sxbvalid/sxbready  in/out  1  B handshake
- sxbresp  in  2  write response
- sxrvalid/sxrready  in/out  1  R handshake
- sxrdata  in  BW_DATA  read data
- sxrresp  in  2  read response
- sxrlast  in  1  ignored (always single beat)

Behaviour:
- Reset values: rhready=1, rhresp=0, rhrdata=0, all valids=0, sxbready=1, sxrready=0, posted counter=0, state IDLE.
- Capture: address phase is accepted when rhready=1 and rhtrans is NONSEQ or SEQ. Address, size, prot and write are registered. IDLE/BUSY trans is ignored, and the next cycle is an OKAY zero-wait.
- Field mapping:
  - axlen=0, axburst=INCR, axsize=rhsize, axlock=rhmasterlock.
  - axprot={~rhprot[0],1'b0,rhprot[1]}.
  - wstrb = ((1<<(1<<size))-1) << addr[log2(BW_DATA/8)-1:0].
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, ERR1, ERR2.
- IDLE:
  - On capture with comm_disable=1 → ERR1.
  - Read capture with posted counter≠0 → RD_ADDR, holding sxarvalid low until counter=0 (ordering).
  - Read capture otherwise → RD_ADDR.
  - Write capture with counter=MAX_POSTED → WR_REQ, holding valids low until counter<MAX_POSTED.
  - Write capture otherwise → WR_REQ.
- rhready drops to 0 the cycle after capture and stays 0 until completion.
- RD_ADDR: sxarvalid=1 until sxarready, then RD_DATA.
- RD_DATA: sxrready=1. On sxrvalid, latch rhrdata.
  - OKAY/EXOKAY → IDLE with rhready=1 for one cycle.
  - SLVERR/DECERR → ERR1.
- WR_REQ: sxawvalid and sxwvalid are raised together. sxwchannel data comes combinationally from rhwdata (stable during AHB wait states). Each valid drops independently on its own handshake. When both are done:
  - WAIT_WRITE_RESPONSE=1 → WR_RESP.
  - WAIT_WRITE_RESPONSE=0 → counter+1, IDLE, rhready=1.
- WR_RESP: on B, OKAY → IDLE with rhready=1; error → ERR1.
- Posted B: sxbready is always 1. Each B decrements the counter. If B and a new posting complete in the same cycle, the counter is unchanged. Posted B errors are not reported to AHB.
- Error response:
  - ERR1: rhresp=1, rhready=0.
  - ERR2: rhresp=1, rhready=1, then IDLE.
  - A new address phase presented during ERR2 is captured normally.
- Latency: read with zero-wait AXI = 3 cycles address-to-data. Posted write = 2 cycles.
- Reset mid-transaction: everything returns to reset values immediately. No AXI valid is held across reset.

Optional Feature:
- Macro: MUNOC_AHB2AXI_POSTED_ERROR_FLAG_EN.
- Defined: adds ports posted_err (out, 1) and posted_err_clear (in, 1).
  - posted_err is sticky, set by any non-OKAY B received while WAIT_WRITE_RESPONSE=0.
  - Cleared by posted_err_clear; set wins when both occur in the same cycle.
  - Reset value 0.
- Undefined: ports absent; posted errors are silently discarded.

Decomposition:
- Shared package/header:
  - BW_ARCHANNEL, BW_AWCHANNEL, BW_WCHANNEL macros and field offsets.
  - AXI burst/resp encodings.
  - AHB trans encodings.
  - State encoding constants.
- Sub-module munoc_ahb2axi_strobe_gen: combinational wstrb from size and address LSBs.

Test Plan:
- Single read, rhaddr=0x100, AXI R=0xDEADBEEF OKAY after 0 waits → sxarchannel addr 0x100, rhrdata=0xDEADBEEF, rhready high 3 cycles after address phase, rhresp=0.
- Byte write to 0x103, rhwdata=0xAB000000, WAIT_WRITE_RESPONSE=0 → wstrb=4'b1000, wlast=1, rhready after 2 cycles, counter=1.
- Five back-to-back posted writes, MAX_POSTED=4, B withheld → fifth write stalls with rhready=0 and no AW/W valid. First B releases it.
- Posted write outstanding, then read → sxarvalid held 0 until B accepted, then read proceeds.
- Read with SLVERR → ERR1 (rhresp=1, rhready=0), ERR2 (rhresp=1, rhready=1), then OKAY.
- comm_disable=1 on write capture → no sxawvalid, two-cycle ERROR. With macro enabled, a DECERR B sets posted_err until posted_err_clear.
